// File: rtl/lfsr_seq_checker_if.sv
// Handshake and result bundle between an LFSR bit source and its sequence checker.
// Latency: none; this is wiring only.
// Backpressure: none; the source presents bits with bit_valid and the checker never stalls.
interface lfsr_seq_checker_if #(
  parameter int WIDTH = 13
);
  logic             start;
  logic             bit_in;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ones_cnt;
  logic [WIDTH-1:0] zeros_cnt;
  logic [WIDTH-1:0] max_run_one;
  logic [WIDTH-1:0] max_run_zero;
  logic             pass;

  // Bit source / controller side
  modport master (
    output start, bit_in, bit_valid,
    input  busy, done, ones_cnt, zeros_cnt, max_run_one, max_run_zero, pass
  );

  // Checker side
  modport slave (
    input  start, bit_in, bit_valid,
    output busy, done, ones_cnt, zeros_cnt, max_run_one, max_run_zero, pass
  );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Statistics checker over one full 2^WIDTH-1 bit period of a maximal-length LFSR stream.
// Latency: done, results and pass register on the edge that accepts the last bit of the window.
// Backpressure: none; gaps in bit_valid simply stall accumulation, one bit per clock at most.
module lfsr_seq_checker #(
  parameter int WIDTH = 13
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  lfsr_seq_checker_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_e;

  // Index of the last bit in the window (N-1 = 2^WIDTH-2).
  localparam logic [WIDTH-1:0] LAST_IDX  = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RUN_MAX   = {WIDTH{1'b1}};
  // m-sequence expectations: 2^(WIDTH-1) ones, one fewer zero.
  localparam logic [WIDTH-1:0] ONES_EXP  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZEROS_EXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] RUN1_LIM  = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] RUN0_LIM  = WIDTH'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] ones_q, ones_d;
  logic [WIDTH-1:0] zeros_q, zeros_d;
  logic [WIDTH-1:0] run_len_q, run_len_d;
  logic             run_val_q, run_val_d;
  logic [WIDTH-1:0] max_one_q, max_one_d;
  logic [WIDTH-1:0] max_zero_q, max_zero_d;
  logic [WIDTH-1:0] res_ones_q, res_ones_d;
  logic [WIDTH-1:0] res_zeros_q, res_zeros_d;
  logic [WIDTH-1:0] res_max_one_q, res_max_one_d;
  logic [WIDTH-1:0] res_max_zero_q, res_max_zero_d;
  logic             pass_q, pass_d;
  // Run maxima including the still-open final run of the window.
  logic [WIDTH-1:0] fin_one, fin_zero;

  // Next-state, accumulation and end-of-window result computation.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    ones_d         = ones_q;
    zeros_d        = zeros_q;
    run_len_d      = run_len_q;
    run_val_d      = run_val_q;
    max_one_d      = max_one_q;
    max_zero_d     = max_zero_q;
    res_ones_d     = res_ones_q;
    res_zeros_d    = res_zeros_q;
    res_max_one_d  = res_max_one_q;
    res_max_zero_d = res_max_zero_q;
    pass_d         = pass_q;
    fin_one        = max_one_q;
    fin_zero       = max_zero_q;

    case (state_q)
      IDLE: begin
        // Window state is held clear while idle; bit_valid is ignored here.
        idx_d      = '0;
        ones_d     = '0;
        zeros_d    = '0;
        run_len_d  = '0;
        run_val_d  = 1'b0;
        max_one_d  = '0;
        max_zero_d = '0;
        if (bus.start) begin
          state_d = ACCUM;
        end
      end

      ACCUM: begin
        if (bus.bit_valid) begin
          idx_d = idx_q + ONE;
          if (bus.bit_in) begin
            ones_d = ones_q + ONE;
          end else begin
            zeros_d = zeros_q + ONE;
          end

          if (idx_q == '0) begin
            run_len_d = ONE;
            run_val_d = bus.bit_in;
          end else if (bus.bit_in == run_val_q) begin
            if (run_len_q != RUN_MAX) begin
              run_len_d = run_len_q + ONE;
            end
          end else begin
            // Value changed: retire the current run into its maximum.
            if (run_val_q) begin
              if (run_len_q > max_one_q) max_one_d = run_len_q;
            end else begin
              if (run_len_q > max_zero_q) max_zero_d = run_len_q;
            end
            run_len_d = ONE;
            run_val_d = bus.bit_in;
          end

          if (idx_q == LAST_IDX) begin
            // Last bit: the open run ends with the window and is not carried over.
            fin_one  = max_one_d;
            fin_zero = max_zero_d;
            if (run_val_d) begin
              if (run_len_d > fin_one) fin_one = run_len_d;
            end else begin
              if (run_len_d > fin_zero) fin_zero = run_len_d;
            end
            res_ones_d     = ones_d;
            res_zeros_d    = zeros_d;
            res_max_one_d  = fin_one;
            res_max_zero_d = fin_zero;
            pass_d         = (ones_d == ONES_EXP) && (zeros_d == ZEROS_EXP) &&
                             (fin_one <= RUN1_LIM) && (fin_zero <= RUN0_LIM);
            state_d        = REPORT;
          end
        end
      end

      REPORT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset clears everything, including held results.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      ones_q         <= '0;
      zeros_q        <= '0;
      run_len_q      <= '0;
      run_val_q      <= 1'b0;
      max_one_q      <= '0;
      max_zero_q     <= '0;
      res_ones_q     <= '0;
      res_zeros_q    <= '0;
      res_max_one_q  <= '0;
      res_max_zero_q <= '0;
      pass_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      ones_q         <= ones_d;
      zeros_q        <= zeros_d;
      run_len_q      <= run_len_d;
      run_val_q      <= run_val_d;
      max_one_q      <= max_one_d;
      max_zero_q     <= max_zero_d;
      res_ones_q     <= res_ones_d;
      res_zeros_q    <= res_zeros_d;
      res_max_one_q  <= res_max_one_d;
      res_max_zero_q <= res_max_zero_d;
      pass_q         <= pass_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == REPORT);
  assign bus.ones_cnt     = res_ones_q;
  assign bus.zeros_cnt    = res_zeros_q;
  assign bus.max_run_one  = res_max_one_q;
  assign bus.max_run_zero = res_max_zero_q;
  assign bus.pass         = pass_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker at WIDTH=4 and WIDTH=13 with a window-level reference model.
// Latency: model predicts done/results on the cycle after the last accepted bit.
// Backpressure: stimulus gaps bit_valid to exercise stalls.
module tb_lfsr_seq_checker;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lfsr_seq_checker_if #(.WIDTH(4))  if4 ();
  lfsr_seq_checker_if #(.WIDTH(13)) if13 ();

  lfsr_seq_checker #(.WIDTH(4))  dut4  (.clk_i(clk), .rst_ni(rst_n), .bus(if4));
  lfsr_seq_checker #(.WIDTH(13)) dut13 (.clk_i(clk), .rst_ni(rst_n), .bus(if13));

  int vectors     = 0;
  int miscompares = 0;

  // Index 0 = WIDTH 4 instance, index 1 = WIDTH 13 instance.
  logic        in_start[2], in_bit[2], in_vld[2];
  logic        o_busy[2], o_done[2], o_pass[2];
  logic [12:0] o_ones[2], o_zeros[2], o_m1[2], o_m0[2];

  assign in_start[0] = if4.start;
  assign in_bit[0]   = if4.bit_in;
  assign in_vld[0]   = if4.bit_valid;
  assign in_start[1] = if13.start;
  assign in_bit[1]   = if13.bit_in;
  assign in_vld[1]   = if13.bit_valid;
  assign o_busy[0]   = if4.busy;
  assign o_done[0]   = if4.done;
  assign o_pass[0]   = if4.pass;
  assign o_ones[0]   = 13'(if4.ones_cnt);
  assign o_zeros[0]  = 13'(if4.zeros_cnt);
  assign o_m1[0]     = 13'(if4.max_run_one);
  assign o_m0[0]     = 13'(if4.max_run_zero);
  assign o_busy[1]   = if13.busy;
  assign o_done[1]   = if13.done;
  assign o_pass[1]   = if13.pass;
  assign o_ones[1]   = if13.ones_cnt;
  assign o_zeros[1]  = if13.zeros_cnt;
  assign o_m1[1]     = if13.max_run_one;
  assign o_m0[1]     = if13.max_run_zero;

  function automatic int wof(input int d);
    return (d == 0) ? 4 : 13;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit win[2][8191];
  int phase[2]    = '{0, 0};   // 0 waiting for start, 1 collecting, 2 reporting
  int nbits[2]    = '{0, 0};
  int exp_busy[2] = '{0, 0};
  int exp_done[2] = '{0, 0};
  int exp_ones[2] = '{0, 0};
  int exp_zero[2] = '{0, 0};
  int exp_m1[2]   = '{0, 0};
  int exp_m0[2]   = '{0, 0};
  int exp_pass[2] = '{0, 0};

  // Statistics of a finished window straight from its stored bits.
  task automatic window_stats(input int d);
    int o, z, m1, m0, run, w;
    bit prev;
    o = 0; z = 0; m1 = 0; m0 = 0; run = 0; prev = 1'b0;
    w = wof(d);
    for (int i = 0; i < (1 << w) - 1; i++) begin
      if (i > 0 && win[d][i] == prev) run++;
      else run = 1;
      prev = win[d][i];
      if (prev) begin
        o++;
        if (run > m1) m1 = run;
      end else begin
        z++;
        if (run > m0) m0 = run;
      end
    end
    exp_ones[d] = o;
    exp_zero[d] = z;
    exp_m1[d]   = m1;
    exp_m0[d]   = m0;
    exp_pass[d] = (o == (1 << (w - 1)) && z == (1 << (w - 1)) - 1 && m1 <= w && m0 <= w - 1) ? 1 : 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        phase[d] = 0; nbits[d] = 0; exp_busy[d] = 0; exp_done[d] = 0;
        exp_ones[d] = 0; exp_zero[d] = 0; exp_m1[d] = 0; exp_m0[d] = 0; exp_pass[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (phase[d] == 0) begin
          if (in_start[d] === 1'b1) begin
            phase[d] = 1; nbits[d] = 0; exp_busy[d] = 1;
          end
        end else if (phase[d] == 1) begin
          if (in_vld[d] === 1'b1) begin
            win[d][nbits[d]] = in_bit[d];
            nbits[d]++;
            if (nbits[d] == (1 << wof(d)) - 1) begin
              window_stats(d);
              exp_done[d] = 1;
              phase[d] = 2;
            end
          end
        end else begin
          exp_done[d] = 0; exp_busy[d] = 0; phase[d] = 0;
        end
      end
    end
  end

  // Every cycle, away from the active edge, every output of both instances.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("w%0d busy", wof(d)),         32'(o_busy[d]), exp_busy[d]);
      chk($sformatf("w%0d done", wof(d)),         32'(o_done[d]), exp_done[d]);
      chk($sformatf("w%0d ones_cnt", wof(d)),     32'(o_ones[d]), exp_ones[d]);
      chk($sformatf("w%0d zeros_cnt", wof(d)),    32'(o_zeros[d]), exp_zero[d]);
      chk($sformatf("w%0d max_run_one", wof(d)),  32'(o_m1[d]), exp_m1[d]);
      chk($sformatf("w%0d max_run_zero", wof(d)), 32'(o_m0[d]), exp_m0[d]);
      chk($sformatf("w%0d pass", wof(d)),         32'(o_pass[d]), exp_pass[d]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drv(input int d, input logic s, input logic v, input logic b);
    if (d == 0) begin
      if4.start = s; if4.bit_valid = v; if4.bit_in = b;
    end else begin
      if13.start = s; if13.bit_valid = v; if13.bit_in = b;
    end
  endtask

  logic [12:0] lfsr;
  logic [14:0] pat;
  logic [14:0] mseq;

  initial begin
    drv(0, 1'b0, 1'b0, 1'b0);
    drv(1, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #3;
    chk("reset w13 busy", 32'(if13.busy), 0);
    chk("reset w13 done", 32'(if13.done), 0);
    chk("reset w13 pass", 32'(if13.pass), 0);
    chk("reset w4 ones_cnt", 32'(if4.ones_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 13-bit m-sequence, valid held high
    @(negedge clk);
    drv(1, 1'b1, 1'b0, 1'b0);
    lfsr = 13'b1000000001101;
    for (int k = 0; k < 8191; k++) begin
      @(negedge clk);
      drv(1, 1'b0, 1'b1, lfsr[12]);
      lfsr = {lfsr[11:0], lfsr[12] ^ lfsr[3] ^ lfsr[2] ^ lfsr[0]};
    end
    @(negedge clk);
    drv(1, 1'b0, 1'b0, 1'b0);
    chk("mseq13 done", 32'(if13.done), 1);
    chk("mseq13 ones", 32'(if13.ones_cnt), 4096);
    chk("mseq13 zeros", 32'(if13.zeros_cnt), 4095);
    chk("mseq13 run1<=13", 32'(if13.max_run_one <= 13'd13), 1);
    chk("mseq13 run0<=12", 32'(if13.max_run_zero <= 13'd12), 1);
    chk("mseq13 pass", 32'(if13.pass), 1);
    chk("model mseq13 ones", exp_ones[1], 4096);
    @(negedge clk);
    chk("mseq13 busy after report", 32'(if13.busy), 0);

    // 13-bit constant ones
    @(negedge clk);
    drv(1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8191; k++) begin
      @(negedge clk);
      drv(1, 1'b0, 1'b1, 1'b1);
    end
    @(negedge clk);
    drv(1, 1'b0, 1'b0, 1'b0);
    chk("ones13 done", 32'(if13.done), 1);
    chk("ones13 ones", 32'(if13.ones_cnt), 8191);
    chk("ones13 zeros", 32'(if13.zeros_cnt), 0);
    chk("ones13 run1", 32'(if13.max_run_one), 8191);
    chk("ones13 run0", 32'(if13.max_run_zero), 0);
    chk("ones13 pass", 32'(if13.pass), 0);

    // 4-bit alternating, valid every other cycle; bit_valid high in the start cycle is ignored
    @(negedge clk);
    drv(0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      drv(0, 1'b0, (k % 2) == 0, ((k / 2) % 2) == 0);
      if (k == 28) chk("alt4 no done at cycle 29", 32'(if4.done), 0);
    end
    chk("alt4 done at cycle 30", 32'(if4.done), 1);
    chk("alt4 ones", 32'(if4.ones_cnt), 8);
    chk("alt4 zeros", 32'(if4.zeros_cnt), 7);
    chk("alt4 run1", 32'(if4.max_run_one), 1);
    chk("alt4 run0", 32'(if4.max_run_zero), 1);
    chk("alt4 pass", 32'(if4.pass), 1);
    @(negedge clk);
    drv(0, 1'b0, 1'b0, 1'b0);

    // 4-bit runs of five, start pulsed mid-window and again while done is high
    pat = 15'b111110000011111;
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      drv(0, k == 7, 1'b1, pat[14-k]);
    end
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 1'b0);
    chk("run5 done", 32'(if4.done), 1);
    chk("run5 ones", 32'(if4.ones_cnt), 10);
    chk("run5 zeros", 32'(if4.zeros_cnt), 5);
    chk("run5 run1", 32'(if4.max_run_one), 5);
    chk("run5 run0", 32'(if4.max_run_zero), 5);
    chk("run5 pass", 32'(if4.pass), 0);
    @(negedge clk);
    drv(0, 1'b0, 1'b0, 1'b0);
    chk("run5 busy after report", 32'(if4.busy), 0);
    chk("run5 single done", 32'(if4.done), 0);
    @(negedge clk);
    chk("run5 no restart", 32'(if4.busy), 0);
    chk("run5 results held", 32'(if4.ones_cnt), 10);

    // 4-bit reset mid-window, between clock edges
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      drv(0, 1'b0, 1'b1, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", 32'(if4.busy), 0);
    chk("async rst ones", 32'(if4.ones_cnt), 0);
    chk("async rst zeros", 32'(if4.zeros_cnt), 0);
    chk("async rst run1", 32'(if4.max_run_one), 0);
    chk("async rst run0", 32'(if4.max_run_zero), 0);
    @(negedge clk);
    drv(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 4-bit m-sequence after reset
    mseq = 15'b000100110101111;
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      drv(0, 1'b0, 1'b1, mseq[14-k]);
    end
    @(negedge clk);
    drv(0, 1'b0, 1'b0, 1'b0);
    chk("mseq4 done", 32'(if4.done), 1);
    chk("mseq4 ones", 32'(if4.ones_cnt), 8);
    chk("mseq4 zeros", 32'(if4.zeros_cnt), 7);
    chk("mseq4 run1", 32'(if4.max_run_one), 4);
    chk("mseq4 run0", 32'(if4.max_run_zero), 3);
    chk("mseq4 pass", 32'(if4.pass), 1);
    chk("model mseq4 run1", exp_m1[0], 4);
    chk("model mseq4 run0", exp_m0[0], 3);
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
